// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: bus widths, execute-to-memory field offsets, load-type bits.
// Also holds the packed layouts of the memory-stage output buses.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD_DFLT = 87;
  localparam int unsigned MS_TO_WS_BUS_WD_DFLT = 70;
  localparam int unsigned MS_FWD_BUS_WD        = 38;

  // es_to_ms_bus = {ld_type[15:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
  localparam int unsigned ES_PC_LSB      = 0;
  localparam int unsigned ES_ALU_LSB     = 32;
  localparam int unsigned ES_DEST_LSB    = 64;
  localparam int unsigned ES_GR_WE_BIT   = 69;
  localparam int unsigned ES_RES_MEM_BIT = 70;
  localparam int unsigned ES_LD_TYPE_LSB = 71;
  localparam int unsigned LD_TYPE_WD     = 16;
  localparam int unsigned LD_TYPE_USED   = 4;

  // One-hot load type; all-zero selects lw.
  localparam int unsigned LD_LB  = 0;
  localparam int unsigned LD_LBU = 1;
  localparam int unsigned LD_LH  = 2;
  localparam int unsigned LD_LHU = 3;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        fwd_we;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
  } ms_fwd_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword from a word and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [3:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    unique case (addr)
      2'b00:   w_byte = word[7:0];
      2'b01:   w_byte = word[15:8];
      2'b10:   w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
  end

  // addr[0] deliberately ignored for halfwords; misalignment is trapped upstream.
  assign w_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    unique case (1'b1)
      ld_type[LD_LB]:  result = ext8(w_byte, 1'b1);
      ld_type[LD_LBU]: result = ext8(w_byte, 1'b0);
      ld_type[LD_LH]:  result = ext16(w_half, 1'b1);
      ld_type[LD_LHU]: result = ext16(w_half, 1'b0);
      default:         result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute-stage instruction, aligns load data and
// holds the synchronous SRAM read word across writeback stalls.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ES_TO_MS_BUS_WD = ES_TO_MS_BUS_WD_DFLT,
  parameter int unsigned MS_TO_WS_BUS_WD = MS_TO_WS_BUS_WD_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  logic                       r_entry;
  logic                       r_rdata_held;
  logic [31:0]                r_rdata_buf;

  logic        w_ms_ready_go;
  logic        w_ms_allowin;
  logic        w_accept;
  logic        w_leave;
  logic [3:0]  w_ld_type;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [31:0] w_ld_word;
  logic [31:0] w_ld_data;
  logic [31:0] w_final_result;
  logic        w_fwd_we;
  ms_to_ws_t   w_ws_bus;
  ms_fwd_t     w_fwd_bus;
  logic        w_unused_ld_type;

  assign w_ms_ready_go = 1'b1;
  assign w_ms_allowin  = !r_ms_valid || (w_ms_ready_go && ws_allowin);
  assign w_accept      = es_to_ms_valid && w_ms_allowin;
  assign w_leave       = r_ms_valid && w_ms_ready_go && ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
      r_es_bus   <= '0;
    end else begin
      if (w_ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (w_accept) begin
        r_es_bus <= es_to_ms_bus;
      end
    end
  end

  // The SRAM word is only valid on the entry cycle; keep it if writeback stalls us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entry      <= 1'b0;
      r_rdata_held <= 1'b0;
      r_rdata_buf  <= '0;
    end else begin
      r_entry <= w_accept;
      if (w_leave || w_accept) begin
        r_rdata_held <= 1'b0;
      end else if (r_entry && r_ms_valid && !ws_allowin) begin
        r_rdata_held <= 1'b1;
        r_rdata_buf  <= data_sram_rdata;
      end
    end
  end

  assign w_ld_type      = r_es_bus[ES_LD_TYPE_LSB +: LD_TYPE_USED];
  assign w_res_from_mem = r_es_bus[ES_RES_MEM_BIT];
  assign w_gr_we        = r_es_bus[ES_GR_WE_BIT];
  assign w_dest         = r_es_bus[ES_DEST_LSB +: 5];
  assign w_alu_result   = r_es_bus[ES_ALU_LSB +: 32];
  assign w_pc           = r_es_bus[ES_PC_LSB +: 32];

  assign w_unused_ld_type = ^r_es_bus[ES_TO_MS_BUS_WD-1:ES_LD_TYPE_LSB+LD_TYPE_USED];

  assign w_ld_word = r_rdata_held ? r_rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .word    (w_ld_word),
    .addr    (w_alu_result[1:0]),
    .ld_type (w_ld_type),
    .result  (w_ld_data)
  );

  assign w_final_result = w_res_from_mem ? w_ld_data : w_alu_result;
  assign w_fwd_we       = r_ms_valid && w_gr_we && (w_dest != 5'd0);

  always_comb begin
    w_ws_bus = '0;
    if (r_ms_valid) begin
      w_ws_bus.gr_we        = w_gr_we;
      w_ws_bus.dest         = w_dest;
      w_ws_bus.final_result = w_final_result;
      w_ws_bus.pc           = w_pc;
    end
  end

  always_comb begin
    w_fwd_bus = '0;
    if (w_fwd_we) begin
      w_fwd_bus.fwd_we   = 1'b1;
      w_fwd_bus.fwd_dest = w_dest;
      w_fwd_bus.fwd_data = w_final_result;
    end
  end

  assign ms_allowin     = w_ms_allowin;
  assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
  assign ms_to_ws_bus   = MS_TO_WS_BUS_WD'(w_ws_bus);
  assign ms_fwd_bus     = w_fwd_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed load/stall/reset cases plus random traffic.
module tb_mem_stage;

  localparam int unsigned EW = 87;
  localparam int unsigned WW = 70;
  localparam int unsigned FW = 38;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ws_allowin = 1'b0;
  logic          ms_allowin;
  logic          es_to_ms_valid = 1'b0;
  logic [EW-1:0] es_to_ms_bus = '0;
  logic [31:0]   data_sram_rdata = '0;
  logic          ms_to_ws_valid;
  logic [WW-1:0] ms_to_ws_bus;
  logic [FW-1:0] ms_fwd_bus;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_fwd_bus      (ms_fwd_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WW-1:0] q_ws[$];
  logic [FW-1:0] q_fwd[$];

  // Reference occupancy model and the instruction currently being offered.
  logic          in_reset = 1'b1;
  logic          model_occ = 1'b0;
  logic          model_allowin = 1'b1;
  logic          cur_es_v = 1'b0;
  logic [WW-1:0] cur_exp_ws = '0;
  logic [FW-1:0] cur_exp_fwd = '0;
  logic [31:0]   cur_word = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_bus(input logic [3:0] ldt, input logic rfm,
                                           input logic we, input logic [4:0] dest,
                                           input logic [31:0] alu, input logic [31:0] pc);
    logic [11:0] hi;
    hi = 12'($urandom);
    return {hi, ldt, rfm, we, dest, alu, pc};
  endfunction

  function automatic logic [31:0] ref_final(input logic [EW-1:0] bus, input logic [31:0] word);
    logic [3:0]  ldt;
    logic [31:0] alu;
    logic [31:0] b;
    logic [31:0] h;
    ldt = bus[74:71];
    alu = bus[63:32];
    if (!bus[70]) return alu;
    b = (word >> (8 * alu[1:0])) & 32'hFF;
    h = alu[1] ? (word >> 16) : (word & 32'hFFFF);
    case (ldt)
      4'b0001: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      4'b0010: return b;
      4'b0100: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      4'b1000: return h;
      default: return word;
    endcase
  endfunction

  // One clock: account for the edge just taken, then present the next cycle's inputs.
  task automatic cycle(input logic es_v, input logic [EW-1:0] bus, input logic [31:0] word,
                       input logic ws, input logic [31:0] filler,
                       input logic use_exp, input logic [31:0] exp_fr);
    logic        entered;
    logic [31:0] fr;
    @(posedge clk);
    entered = cur_es_v && model_allowin;
    if (model_allowin) model_occ = cur_es_v;
    if (entered) begin
      q_ws.push_back(cur_exp_ws);
      q_fwd.push_back(cur_exp_fwd);
    end
    #1;
    data_sram_rdata = entered ? cur_word : filler;
    fr = use_exp ? exp_fr : ref_final(bus, word);
    cur_es_v    = es_v;
    cur_word    = word;
    cur_exp_ws  = {bus[69], bus[68:64], fr, bus[31:0]};
    cur_exp_fwd = (bus[69] && bus[68:64] != 5'd0) ? {1'b1, bus[68:64], fr} : '0;
    es_to_ms_valid = es_v;
    es_to_ms_bus   = bus;
    ws_allowin     = ws;
    model_allowin  = !model_occ || ws;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, $urandom, 1'b1, $urandom, 1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      check("allowin", 128'(ms_allowin), 128'(model_allowin));
      check("valid", 128'(ms_to_ws_valid), 128'(model_occ));
      if (ms_to_ws_valid) begin
        if (q_ws.size() == 0) begin
          check("sb_empty", 128'(1), 128'(0));
        end else begin
          check("ws_bus", 128'(ms_to_ws_bus), 128'(q_ws[0]));
          check("fwd_bus", 128'(ms_fwd_bus), 128'(q_fwd[0]));
          if (ws_allowin) begin
            void'(q_ws.pop_front());
            void'(q_fwd.pop_front());
          end
        end
      end else begin
        check("idle_bus", 128'({ms_to_ws_bus, ms_fwd_bus}), 128'(0));
      end
    end
  end

  initial begin
    logic [3:0] ldt;
    int         sel;

    #3;
    check("rst_valid", 128'(ms_to_ws_valid), 128'(0));
    check("rst_allowin", 128'(ms_allowin), 128'(1));
    check("rst_bus", 128'({ms_to_ws_bus, ms_fwd_bus}), 128'(0));
    #4 reset = 1'b0;
    in_reset = 1'b0;

    // Byte/halfword/word extraction, back-to-back loads.
    cycle(1, mk_bus(4'b0001, 1, 1, 5'd3, 32'h1000_0003, 32'h100), 32'h8012_3456, 1,
          $urandom, 1, 32'hFFFF_FF80);
    cycle(1, mk_bus(4'b0010, 1, 1, 5'd4, 32'h1000_0003, 32'h104), 32'h8012_3456, 1,
          $urandom, 1, 32'h0000_0080);
    cycle(1, mk_bus(4'b0100, 1, 1, 5'd5, 32'h1000_0002, 32'h108), 32'h8001_7FFF, 1,
          $urandom, 1, 32'hFFFF_8001);
    cycle(1, mk_bus(4'b1000, 1, 1, 5'd6, 32'h1000_0002, 32'h10C), 32'h8001_7FFF, 1,
          $urandom, 1, 32'h0000_8001);
    cycle(1, mk_bus(4'b0000, 1, 1, 5'd7, 32'h1000_0002, 32'h110), 32'h8001_7FFF, 1,
          $urandom, 1, 32'h8001_7FFF);
    idle(2);

    // Stall with the SRAM output changing after the entry cycle.
    cycle(1, mk_bus(4'b0000, 1, 1, 5'd8, 32'h2000_0000, 32'h200), 32'h1234_5678, 0,
          $urandom, 1, 32'h1234_5678);
    cycle(0, '0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0);
    cycle(0, '0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0);
    cycle(0, '0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0);
    cycle(0, '0, 32'h0, 1, 32'hDEAD_BEEF, 0, 32'h0);
    idle(2);

    // Back-to-back ALU ops, including a write to r0.
    cycle(1, mk_bus(4'b0000, 0, 1, 5'd9, 32'hCAFE_0001, 32'h300), $urandom, 1, $urandom, 0, 0);
    cycle(1, mk_bus(4'b0000, 0, 1, 5'd0, 32'hCAFE_0002, 32'h304), $urandom, 1, $urandom, 0, 0);
    cycle(1, mk_bus(4'b0000, 0, 0, 5'd10, 32'hCAFE_0003, 32'h308), $urandom, 1, $urandom, 0, 0);
    cycle(1, mk_bus(4'b0000, 0, 1, 5'd31, 32'hCAFE_0004, 32'h30C), $urandom, 1, $urandom, 0, 0);
    idle(2);

    // Leave and enter together after a stall: the new load must use live SRAM data.
    cycle(1, mk_bus(4'b0000, 1, 1, 5'd11, 32'h4000_0000, 32'h400), 32'hAAAA_AAAA, 0,
          $urandom, 1, 32'hAAAA_AAAA);
    cycle(0, '0, 32'h0, 0, $urandom, 0, 32'h0);
    cycle(0, '0, 32'h0, 0, $urandom, 0, 32'h0);
    cycle(1, mk_bus(4'b1000, 1, 1, 5'd12, 32'h4000_0004, 32'h404), 32'h0000_F00D, 1,
          $urandom, 1, 32'h0000_F00D);
    idle(3);

    // Asynchronous reset while a stalled load is held.
    cycle(1, mk_bus(4'b0000, 1, 1, 5'd13, 32'h5000_0000, 32'h500), 32'h5555_0000, 0,
          $urandom, 0, 32'h0);
    cycle(0, '0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0);
    cycle(0, '0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0);
    check("held_set", 128'(dut.r_rdata_held), 128'(1));
    #2 reset = 1'b1;
    in_reset = 1'b1;
    #1;
    check("arst_valid", 128'(ms_to_ws_valid), 128'(0));
    check("arst_held", 128'(dut.r_rdata_held), 128'(0));
    check("arst_allowin", 128'(ms_allowin), 128'(1));
    check("arst_bus", 128'({ms_to_ws_bus, ms_fwd_bus}), 128'(0));
    @(posedge clk);
    #2 reset = 1'b0;
    model_occ     = 1'b0;
    model_allowin = 1'b1;
    cur_es_v      = 1'b0;
    q_ws.delete();
    q_fwd.delete();
    #1 in_reset = 1'b0;
    cycle(1, mk_bus(4'b0001, 1, 1, 5'd14, 32'h6000_0001, 32'h600), 32'h0000_7F00, 0,
          $urandom, 1, 32'h0000_007F);
    cycle(0, '0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0);
    cycle(0, '0, 32'h0, 1, 32'hDEAD_BEEF, 0, 32'h0);
    idle(2);

    // Random traffic with random writeback back-pressure.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 4));
      ldt = (sel == 0) ? 4'b0000 : 4'(1 << (sel - 1));
      cycle($urandom_range(0, 9) < 7,
            mk_bus(ldt, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, $urandom),
            $urandom, $urandom_range(0, 9) < 6, $urandom, 0, 32'h0);
    end

    idle(10);
    check("drain", 128'(q_ws.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ES_TO_MS_BUS_WD, default 87, width of the bus from the execute stage.
REQ-002 Parameter MS_TO_WS_BUS_WD, default 70, width of the bus to the writeback stage.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ws_allowin  in  1  writeback stage can accept a new instruction this cycle.
REQ-006 ms_allowin  out  1  this stage can accept from execute this cycle.
REQ-007 es_to_ms_valid  in  1  execute stage offers an instruction.
REQ-008 es_to_ms_bus  in  ES_TO_MS_BUS_WD  fields: {ld_type[15:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first; ld_type[3:0] one-hot {lhu,lh,lbu,lb}, all-zero means lw; ld_type[15:4] ignored.
REQ-009 data_sram_rdata  in  32  synchronous SRAM read data, valid in the first cycle an instruction occupies this stage.
REQ-010 ms_to_ws_valid  out  1  this stage offers an instruction to writeback.
REQ-011 ms_to_ws_bus  out  MS_TO_WS_BUS_WD  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
REQ-012 ms_fwd_bus  out  38  {fwd_we, fwd_dest[4:0], fwd_data[31:0]} bypass to decode.

Function
REQ-013 ms_valid register SHALL load es_to_ms_valid whenever ms_allowin=1; the bus register SHALL load es_to_ms_bus only when es_to_ms_valid=1 and ms_allowin=1.
REQ-014 ms_ready_go SHALL be 1; ms_allowin = !ms_valid | ws_allowin; ms_to_ws_valid = ms_valid.
REQ-015 A 1-bit flag rdata_held and a 32-bit register rdata_buf SHALL exist: on the first cycle of an instruction in the stage (entry flag set) with ws_allowin=0, rdata_buf captures data_sram_rdata and rdata_held sets.
REQ-016 rdata_held SHALL clear when the instruction leaves (ms_valid & ws_allowin) or a new instruction enters; a simultaneous leave and enter SHALL clear it, not set it.
REQ-017 Effective load word = rdata_held ? rdata_buf : data_sram_rdata.
REQ-018 Byte select by alu_result[1:0]; lb/lbu SHALL take byte [8*a+7:8*a], sign/zero-extended to 32 bits.
REQ-019 lh/lhu SHALL take the halfword at alu_result[1] (0: [15:0], 1: [31:16]), sign/zero-extended; alu_result[0] is ignored (no address exception in this stage).
REQ-020 lw SHALL pass the word unchanged.
REQ-021 final_result = res_from_mem ? extended load data : alu_result.
REQ-022 ms_to_ws_bus SHALL be all-zero when ms_valid=0.
REQ-023 fwd_we = ms_valid & gr_we & (dest != 0); fwd_dest = dest; fwd_data = final_result; all fields SHALL be zero when fwd_we=0.
REQ-024 Latency SHALL be one cycle from acceptance to ms_to_ws_valid; there are no bubbles under continuous ws_allowin=1.

Reset
REQ-025 On reset assertion, ms_valid, rdata_held, rdata_buf and the bus register SHALL clear immediately, without waiting for a clock edge.
REQ-026 During reset, ms_to_ws_valid=0, ms_to_ws_bus=0, ms_fwd_bus=0 and ms_allowin=1.
REQ-027 Reset asserted mid-stall SHALL drop the held instruction; after release, the first accepted instruction SHALL behave as on power-up.

Structure
REQ-028 Bus widths, bus field offsets and the ld_type bit assignments SHALL live in the shared package/header used by all pipeline stages.
REQ-029 Load alignment and extension SHALL be one combinational sub-module, load_align (inputs: word, addr[1:0], ld_type[3:0]; output: 32-bit result).

Verification
REQ-030 lb, addr low bits 2'b11, rdata 32'h80_12_34_56 -> final_result 32'hFFFF_FF80; same with lbu -> 32'h0000_0080.
REQ-031 lh, addr low bits 2'b10, rdata 32'h8001_7FFF -> 32'hFFFF_8001; lhu -> 32'h0000_8001; lw -> 32'h8001_7FFF.
REQ-032 Load enters with ws_allowin=0 for 3 cycles while data_sram_rdata changes to 32'hDEAD_BEEF after cycle 1 -> ms_to_ws_bus keeps the first-cycle data, and the instruction transfers once ws_allowin=1.
REQ-033 Back-to-back ALU ops, ws_allowin=1 -> one instruction out per cycle; dest=0 with gr_we=1 -> fwd_we=0.
REQ-034 Reset pulse asynchronous to clk while a stalled load is held -> ms_to_ws_valid falls within the same cycle, rdata_held=0, ms_allowin=1.
REQ-035 Simultaneous leave and enter (ws_allowin=1, es_to_ms_valid=1) after a stall -> the new instruction uses live data_sram_rdata, not the stale rdata_buf.
